dmem_responder: RTL

// - Data-memory responder on the far side of the MEM-stage load/store interface; MEM stage initiates, this block serves.
// - Word-organised synchronous RAM behind a valid/ready request and a one-cycle response pulse.
// - Models multi-cycle memory latency; raises mem_stall so the pipeline holds MEM-stage inputs until data returns.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master) and the data memory (slave).
// Latency: none; this is wiring only. Backpressure: req_ready and mem_stall flow from slave to master.
// Signals: req_valid/req_write/req_addr/req_wdata (request), req_ready/mem_stall, resp_valid/resp_rdata/resp_err.
interface dmem_responder_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_write;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 req_ready;
    logic                 mem_stall;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, mem_stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, mem_stall, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised synchronous RAM serving MEM-stage loads and stores.
// Latency: LATENCY cycles from request accept to a one-cycle resp_valid pulse.
// Backpressure: req_ready only in IDLE; mem_stall holds the pipeline until the response cycle.
// Ports: clk, rst_n (async active-low), bus (dmem_responder_if.slave).
// Optional: define DMEM_MISALIGN_CHECK_EN to flag req_addr[1:0]!=0 with resp_err and suppress the access;
// otherwise the low address bits are ignored and resp_err is tied low.
module dmem_responder #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input logic               clk,
    input logic               rst_n,
    dmem_responder_if.slave   bus
);
    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;

    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [WORD_SIZE-1:0]    lat_wdata;
    logic                    lat_mis;

    logic [WORD_SIZE-1:0]    mem [DEPTH];
    logic [WORD_SIZE-1:0]    rdata_q;
    logic                    err_q;

    logic                    accept;
    logic                    req_mis;
    logic                    enter_resp;
    logic                    mem_we;
    logic                    acc_write;
    logic                    acc_mis;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [WORD_SIZE-1:0]    acc_wdata;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic unused_addr_hi;
    assign req_mis        = (bus.req_addr[1:0] != 2'b00);
    assign unused_addr_hi = ^bus.req_addr[WORD_SIZE-1:ADDR_WIDTH+2];
`else
    logic unused_addr_bits;
    assign req_mis          = 1'b0;
    assign unused_addr_bits = ^{bus.req_addr[WORD_SIZE-1:ADDR_WIDTH+2], bus.req_addr[1:0]};
`endif

    assign accept = (state == IDLE) && bus.req_valid;

    // With LATENCY==1 the RAM is touched on the same edge that accepts the
    // request, so the access fields come straight from the bus in IDLE.
    assign acc_write  = (state == IDLE) ? bus.req_write                    : lat_write;
    assign acc_idx    = (state == IDLE) ? bus.req_addr[ADDR_WIDTH+1:2]     : lat_idx;
    assign acc_wdata  = (state == IDLE) ? bus.req_wdata                    : lat_wdata;
    assign acc_mis    = (state == IDLE) ? req_mis                          : lat_mis;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);
    // rst_n gating keeps a reset-aborted access from ever reaching the array.
    assign mem_we     = rst_n && enter_resp && acc_write && !acc_mis;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt <= 4'd1)   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.mem_stall  = accept || (state == BUSY);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata_q;
`ifdef DMEM_MISALIGN_CHECK_EN
        bus.resp_err   = err_q;
`else
        bus.resp_err   = 1'b0;
`endif
    end

`ifndef DMEM_MISALIGN_CHECK_EN
    logic unused_err;
    assign unused_err = err_q;
`endif

    // Request latch and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_mis   <= 1'b0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            lat_write <= bus.req_write;
            lat_idx   <= bus.req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= bus.req_wdata;
            lat_mis   <= req_mis;
        end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response data: loaded on the edge into RESP, cleared on the edge out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (!acc_write && !acc_mis) ? mem[acc_idx] : '0;
            err_q   <= acc_mis;
        end else if (state == RESP) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // RAM array, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule
